// File: rtl/jk_q_monitor_if.sv
// jk_q_monitor_if: JK output pair, clear and monitor results bundled for the monitor
// master: drives q/qb/clr, observes counters and flags
// slave : the monitor; samples q/qb/clr, drives counters and flags
interface jk_q_monitor_if #(parameter int CNT_W = 8);
    logic             q;
    logic             qb;
    logic             clr;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       toggle_run;
    logic             osc_flag;
    logic             comp_err;
    logic             q_level;
    modport master(output q, qb, clr,
                   input rise_cnt, fall_cnt, err_cnt, toggle_run, osc_flag, comp_err, q_level);
    modport slave(input q, qb, clr,
                  output rise_cnt, fall_cnt, err_cnt, toggle_run, osc_flag, comp_err, q_level);
endinterface

// File: rtl/jk_q_monitor.sv
// jk_q_monitor: tracks a JK flip-flop's q/qb pair, counting edges, complement faults and toggle runs
// clk/rst : clock and synchronous active-high reset
// bus     : slave side of jk_q_monitor_if (q, qb, clr in; counters and flags out, all registered)
module jk_q_monitor #(
    parameter int CNT_W   = 8,
    parameter int OSC_LEN = 4
) (
    input logic          clk,
    input logic          rst,
    jk_q_monitor_if.slave bus
);
    typedef enum logic [1:0] {INIT, LOW, HIGH, ERR} state_t;
    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [3:0]       OSC_L = 4'(OSC_LEN);
    state_t           state, state_nx;
    logic [CNT_W-1:0] rise, fall, err, rise_nx, fall_nx, err_nx;
    logic [3:0]       run, run_raw, run_nx;
    logic             osc, osc_nx, cerr, lvl, lvl_nx;
    logic             valid, rise_e, fall_e, err_e;
    assign valid = bus.q ^ bus.qb;
    always_comb begin
        state_nx = state;
        rise_e   = 1'b0;
        fall_e   = 1'b0;
        err_e    = 1'b0;
        case (state)
            LOW: begin
                state_nx = !valid ? ERR : (bus.q ? HIGH : LOW);
                err_e    = !valid;
                rise_e   = valid && bus.q;
            end
            HIGH: begin
                state_nx = !valid ? ERR : (bus.q ? HIGH : LOW);
                err_e    = !valid;
                fall_e   = valid && !bus.q;
            end
            default: state_nx = !valid ? ERR : (bus.q ? HIGH : LOW);
        endcase
        // any non-edge cycle breaks the run; the run itself saturates at 15
        run_raw = (rise_e || fall_e) ? ((run == 4'hf) ? run : run + 4'd1) : 4'd0;
        run_nx  = bus.clr ? 4'd0 : run_raw;
        osc_nx  = !bus.clr && (osc || run_raw >= OSC_L);
        rise_nx = bus.clr ? '0 : (rise_e && rise != CMAX) ? rise + 1'b1 : rise;
        fall_nx = bus.clr ? '0 : (fall_e && fall != CMAX) ? fall + 1'b1 : fall;
        err_nx  = bus.clr ? '0 : (err_e && err != CMAX) ? err + 1'b1 : err;
        lvl_nx  = valid ? bus.q : lvl;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            rise  <= '0;
            fall  <= '0;
            err   <= '0;
            run   <= 4'd0;
            osc   <= 1'b0;
            cerr  <= 1'b0;
            lvl   <= 1'b0;
        end else begin
            state <= state_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
            err   <= err_nx;
            run   <= run_nx;
            osc   <= osc_nx;
            cerr  <= state_nx == ERR;
            lvl   <= lvl_nx;
        end
    end
    assign bus.rise_cnt   = rise;
    assign bus.fall_cnt   = fall;
    assign bus.err_cnt    = err;
    assign bus.toggle_run = run;
    assign bus.osc_flag   = osc;
    assign bus.comp_err   = cerr;
    assign bus.q_level    = lvl;
endmodule

// File: tb/tb_jk_q_monitor.sv
// tb_jk_q_monitor: directed and random stimulus on 8-bit and 3-bit counter monitors, checked against an event-level model
module tb_jk_q_monitor;
    localparam int OSC_LEN = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q = 1'b0, qb = 1'b1, clr = 1'b0;
    int checks = 0, errors = 0;
    int n_rise, n_fall, n_err, run_len;
    bit m_osc, m_known, m_in_err, m_level;
    bit prev_rst;
    jk_q_monitor_if #(.CNT_W(8)) b8 ();
    jk_q_monitor_if #(.CNT_W(3)) b3 ();
    assign b8.q = q;
    assign b8.qb = qb;
    assign b8.clr = clr;
    assign b3.q = q;
    assign b3.qb = qb;
    assign b3.clr = clr;
    jk_q_monitor #(.CNT_W(8), .OSC_LEN(OSC_LEN)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    jk_q_monitor #(.CNT_W(3), .OSC_LEN(OSC_LEN)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Event-level view: a level change between two valid samples is an edge unless
    // the previous cycle was a fault or there was no valid level since reset.
    task automatic model_step();
        bit valid, edge_seen;
        if (rst) begin
            n_rise = 0; n_fall = 0; n_err = 0; run_len = 0;
            m_osc = 0; m_known = 0; m_in_err = 0; m_level = 0;
            return;
        end
        valid = q != qb;
        if (valid) begin
            edge_seen = m_known && !m_in_err && q != m_level;
            if (edge_seen && q) n_rise++;
            if (edge_seen && !q) n_fall++;
            run_len = edge_seen ? run_len + 1 : 0;
            m_level = q;
            m_known = 1;
            m_in_err = 0;
        end else begin
            if (m_known && !m_in_err) n_err++;
            run_len = 0;
            m_in_err = 1;
        end
        if (run_len >= OSC_LEN) m_osc = 1;
        if (clr) begin
            n_rise = 0; n_fall = 0; n_err = 0; run_len = 0; m_osc = 0;
        end
    endtask

    task automatic check_all();
        chk("rise8", int'(b8.rise_cnt), sat(n_rise, 255));
        chk("fall8", int'(b8.fall_cnt), sat(n_fall, 255));
        chk("err8", int'(b8.err_cnt), sat(n_err, 255));
        chk("run8", int'(b8.toggle_run), sat(run_len, 15));
        chk("osc8", int'(b8.osc_flag), int'(m_osc));
        chk("cerr8", int'(b8.comp_err), int'(m_in_err));
        chk("lvl8", int'(b8.q_level), int'(m_level));
        chk("rise3", int'(b3.rise_cnt), sat(n_rise, 7));
        chk("fall3", int'(b3.fall_cnt), sat(n_fall, 7));
        chk("err3", int'(b3.err_cnt), sat(n_err, 7));
        chk("run3", int'(b3.toggle_run), sat(run_len, 15));
    endtask

    task automatic cyc(input logic iq, input logic iqb, input logic iclr, input logic irst);
        q = iq; qb = iqb; clr = iclr; rst = irst;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        #1;
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("reset_rise", int'(b8.rise_cnt), 0);
        chk("reset_lvl", int'(b8.q_level), 0);
        chk("reset_cerr", int'(b8.comp_err), 0);
        // hold low
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        chk("hold_rise", int'(b8.rise_cnt), 0);
        chk("hold_osc", int'(b8.osc_flag), 0);
        // toggle six cycles starting from LOW
        for (int i = 0; i < 6; i++) begin
            cyc(~i[0], i[0], 0, 0);
            if (i == 3) chk("tog_osc4", int'(b8.osc_flag), 1);
            if (i == 2) chk("tog_osc3", int'(b8.osc_flag), 0);
        end
        chk("tog_rise", int'(b8.rise_cnt), 3);
        chk("tog_fall", int'(b8.fall_cnt), 3);
        chk("tog_run", int'(b8.toggle_run), 6);
        // complement fault from LOW, recovering high
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0);
            chk("cf_cerr_hi", int'(b8.comp_err), 1);
        end
        cyc(1, 0, 0, 0);
        chk("cf_cerr_lo", int'(b8.comp_err), 0);
        chk("cf_err", int'(b8.err_cnt), 1);
        chk("cf_rise", int'(b8.rise_cnt), 3);
        chk("cf_lvl", int'(b8.q_level), 1);
        // clear colliding with a rising edge
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        chk("clr_rise", int'(b8.rise_cnt), 0);
        chk("clr_fall", int'(b8.fall_cnt), 0);
        chk("clr_err", int'(b8.err_cnt), 0);
        chk("clr_lvl", int'(b8.q_level), 1);
        cyc(0, 1, 0, 0);
        chk("clr_state_high", int'(b8.fall_cnt), 1);
        // saturation on the 3-bit instance
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 1, 0, 0);
        end
        chk("sat3_rise", int'(b3.rise_cnt), 7);
        chk("sat8_rise", int'(b8.rise_cnt), 10);
        // mid-run reset
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 1);
        chk("mr_rise", int'(b8.rise_cnt), 0);
        chk("mr_osc", int'(b8.osc_flag), 0);
        chk("mr_lvl", int'(b8.q_level), 0);
        cyc(0, 1, 0, 0);
        chk("mr_run", int'(b8.toggle_run), 0);
        chk("mr_fall", int'(b8.fall_cnt), 0);
        cyc(1, 0, 0, 0);
        chk("mr_edge", int'(b8.rise_cnt), 1);
        // random traffic
        prev_rst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rq, rqb, rc, rr;
            rq = 1'($urandom);
            rqb = ($urandom_range(0, 7) == 0) ? rq : ~rq;
            if (prev_rst) rqb = ~rq;
            rc = ($urandom_range(0, 31) == 0);
            rr = ($urandom_range(0, 99) == 0);
            prev_rst = rr;
            cyc(rq, rqb, rc, rr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
